// File: rtl/apb_pkg.sv
// Shared definitions for the APB slave register interface:
// FSM state encoding, register-bank strobe codes and a constant clog2 helper.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01
  } state_e;

  localparam logic [1:0] REG_NONE = 2'b00;
  localparam logic [1:0] REG_WR   = 2'b01;
  localparam logic [1:0] REG_RD   = 2'b10;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational PADDR decode: word index plus an error flag for misaligned
// or out-of-range addresses.
module apb_addr_decoder
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int NB         = 4,
  parameter int NUM_REGS   = 8,
  localparam int ADDR_LSB  = clog2(NB),
  localparam int IDX_W     = (clog2(NUM_REGS) > 0) ? clog2(NUM_REGS) : 1
) (
  input  logic [ADDR_WIDTH-1:0] paddr,
  output logic [IDX_W-1:0]      index,
  output logic                  error
);

  localparam int FULL_W = ADDR_WIDTH - ADDR_LSB;

  logic [FULL_W-1:0] full_idx;
  logic [31:0]       full_ext;
  logic              misaligned;

  assign full_idx = paddr[ADDR_WIDTH-1:ADDR_LSB];
  assign full_ext = 32'(full_idx);

  // Byte-wide buses have no sub-word offset bits, so they can never be misaligned.
  generate
    if (ADDR_LSB > 0) begin : g_lsb
      assign misaligned = |paddr[ADDR_LSB-1:0];
    end else begin : g_no_lsb
      assign misaligned = 1'b0;
    end
  endgenerate

  assign error = misaligned | (full_ext >= 32'(NUM_REGS));
  assign index = full_idx[IDX_W-1:0];

endmodule

// File: rtl/apb_slave_regif.sv
// APB3/APB4 slave front-end for the ECC accelerator register bank: address
// decode, programmable wait states, PSLVERR and the 2-bit REG_ENABLE strobe.
module apb_slave_regif
  import apb_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int NUM_REGS    = 8,
  parameter int WAIT_STATES = 0,
  localparam int NB         = DATA_WIDTH / 8,
  localparam int IDX_W      = (clog2(NUM_REGS) > 0) ? clog2(NUM_REGS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [NB-1:0]         PSTRB,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic [1:0]            REG_ENABLE,
  output logic [IDX_W-1:0]      REG_INDEX,
  output logic [DATA_WIDTH-1:0] REG_WDATA,
  output logic [NB-1:0]         REG_WSTRB,
  input  logic [DATA_WIDTH-1:0] REG_RDATA
);

  localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic             err_q, err_d;
  logic             write_q, write_d;

  logic [IDX_W-1:0] dec_index;
  logic             dec_err;
  logic             ready;
  logic             complete;

  apb_addr_decoder #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .NB        (NB),
    .NUM_REGS  (NUM_REGS)
  ) u_decoder (
    .paddr(PADDR),
    .index(dec_index),
    .error(dec_err)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      index_q <= '0;
      err_q   <= 1'b0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      index_q <= index_d;
      err_q   <= err_d;
      write_q <= write_d;
    end
  end

  // A setup phase (PSEL without PENABLE) always restarts the access, even mid-WAIT.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    index_d = index_q;
    err_d   = err_q;
    write_d = write_q;
    case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          state_d = WAIT;
          cnt_d   = CNT_INIT;
          index_d = dec_index;
          err_d   = dec_err;
          write_d = PWRITE;
        end
      end
      WAIT: begin
        if (!PSEL) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (!PENABLE) begin
          cnt_d   = CNT_INIT;
          index_d = dec_index;
          err_d   = dec_err;
          write_d = PWRITE;
        end else if (cnt_q == 4'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // PREADY is gated by PSEL so an abort never shows a ready pulse.
  always_comb begin
    ready      = (state_q == WAIT) && (cnt_q == 4'd0) && PSEL;
    complete   = ready && PENABLE;
    PREADY     = ready;
    PSLVERR    = 1'b0;
    REG_ENABLE = REG_NONE;
    REG_WSTRB  = '0;
    PRDATA     = '0;
    REG_WDATA  = PWDATA;
    REG_INDEX  = index_q;
    if (complete) begin
      PSLVERR = err_q;
      if (!err_q) begin
        REG_ENABLE = write_q ? REG_WR : REG_RD;
      end
      if (write_q) begin
        REG_WSTRB = PSTRB;
      end else if (!err_q) begin
        PRDATA = REG_RDATA;
      end
    end
  end

endmodule
